// File: rtl/commit_monitor.sv
// Retirement monitor for the forwarding RISC-V core.
// Counts retired instructions and RUN cycles, keeps a ring buffer of the most
// recent retired PCs, and latches either a halt (same PC retired repeatedly)
// or a timeout (no retirement for too long). Both end states are terminal
// until reset or i_clear.
//
// Handshake: i_insn_vld is a one-way strobe with no ready. Every cycle it is
// high in IDLE or RUN is one accepted retirement of i_pc. In HALTED or
// TIMEOUT it is ignored.
module commit_monitor #(
  parameter int PC_WIDTH       = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int TRACE_DEPTH    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int HALT_REPEAT    = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_clear,
  input  logic                           i_insn_vld,
  input  logic [PC_WIDTH-1:0]            i_pc,
  input  logic [$clog2(TRACE_DEPTH)-1:0] i_trace_idx,
  output logic [PC_WIDTH-1:0]            o_trace_pc,
  output logic                           o_trace_vld,
  output logic [CNT_WIDTH-1:0]           o_retire_cnt,
  output logic [CNT_WIDTH-1:0]           o_cycle_cnt,
  output logic                           o_running,
  output logic                           o_halted,
  output logic                           o_timeout,
  output logic [PC_WIDTH-1:0]            o_halt_pc,
  output logic [1:0]                     o_fsm_state
);

  localparam int AW     = $clog2(TRACE_DEPTH);
  localparam int FILL_W = $clog2(TRACE_DEPTH + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int REP_W  = $clog2(HALT_REPEAT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_HALTED  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  logic [1:0]           state_q,      state_d;
  logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q,  cycle_cnt_d;
  logic [IDLE_W-1:0]    idle_cnt_q,   idle_cnt_d;
  logic [REP_W-1:0]     rep_cnt_q,    rep_cnt_d;
  logic [PC_WIDTH-1:0]  last_pc_q,    last_pc_d;
  logic [AW-1:0]        wr_ptr_q,     wr_ptr_d;
  logic [FILL_W-1:0]    fill_q,       fill_d;
  logic                 halted_q,     halted_d;
  logic                 timeout_q,    timeout_d;
  logic [PC_WIDTH-1:0]  halt_pc_q,    halt_pc_d;
  logic [PC_WIDTH-1:0]  trace_q [TRACE_DEPTH];
  logic                 accept;
  logic [AW-1:0]        rd_ptr;

  // A retirement is only taken while the monitor is still live.
  assign accept = i_insn_vld && ((state_q == ST_IDLE) || (state_q == ST_RUN));

  // Next-state for FSM, counters, halt detection and trace pointers.
  always_comb begin
    state_d      = state_q;
    retire_cnt_d = retire_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    last_pc_d    = last_pc_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    halted_d     = halted_q;
    timeout_d    = timeout_q;
    halt_pc_d    = halt_pc_q;

    if (accept) begin
      if (retire_cnt_q != '1) retire_cnt_d = retire_cnt_q + 1'b1;
      wr_ptr_d  = wr_ptr_q + 1'b1;
      if (fill_q != FILL_W'(TRACE_DEPTH)) fill_d = fill_q + 1'b1;
      last_pc_d = i_pc;
      // The first retirement out of IDLE always starts a fresh run of 1.
      if ((state_q == ST_RUN) && (i_pc == last_pc_q)) rep_cnt_d = rep_cnt_q + 1'b1;
      else                                            rep_cnt_d = REP_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_RUN;
          cycle_cnt_d = CNT_WIDTH'(1);
          idle_cnt_d  = '0;
        end
      end
      ST_RUN: begin
        if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
        idle_cnt_d = accept ? '0 : idle_cnt_q + 1'b1;
        // A retirement clears the idle count, so it always beats a timeout.
        if (accept && (rep_cnt_d == REP_W'(HALT_REPEAT))) begin
          state_d   = ST_HALTED;
          halted_d  = 1'b1;
          halt_pc_d = i_pc;
        end else if (!accept && (idle_cnt_d == IDLE_W'(TIMEOUT_CYCLES))) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
        end
      end
      default: ; // HALTED and TIMEOUT hold everything
    endcase
  end

  // Control and status registers; i_clear acts like a synchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      retire_cnt_q <= '0;
      cycle_cnt_q  <= '0;
      idle_cnt_q   <= '0;
      rep_cnt_q    <= '0;
      last_pc_q    <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      halt_pc_q    <= '0;
    end else if (i_clear) begin
      state_q      <= ST_IDLE;
      retire_cnt_q <= '0;
      cycle_cnt_q  <= '0;
      idle_cnt_q   <= '0;
      rep_cnt_q    <= '0;
      last_pc_q    <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      halt_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      last_pc_q    <= last_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
      halt_pc_q    <= halt_pc_d;
    end
  end

  // Trace ring buffer: write the accepted PC at the write pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < TRACE_DEPTH; i++) trace_q[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < TRACE_DEPTH; i++) trace_q[i] <= '0;
    end else if (accept) begin
      trace_q[wr_ptr_q] <= i_pc;
    end
  end

  // Index 0 is the newest entry; pointer arithmetic wraps modulo the depth.
  assign rd_ptr      = wr_ptr_q - AW'(1) - i_trace_idx;
  assign o_trace_vld = ({1'b0, i_trace_idx} < fill_q);
  assign o_trace_pc  = o_trace_vld ? trace_q[rd_ptr] : '0;

  assign o_retire_cnt = retire_cnt_q;
  assign o_cycle_cnt  = cycle_cnt_q;
  assign o_running    = (state_q == ST_RUN);
  assign o_halted     = halted_q;
  assign o_timeout    = timeout_q;
  assign o_halt_pc    = halt_pc_q;
  assign o_fsm_state  = state_q;

endmodule

// File: doc/commit_monitor.md
Name: commit_monitor

Overview:
- Synthesizable retirement monitor for the forwarding RISC-V core. It taps the core's debug PC and instruction-valid outputs.
- Counts retired instructions and elapsed cycles, keeps a ring buffer of the last TRACE_DEPTH retired PCs, and detects two end conditions:
  - a halt, i.e. a self-loop on the same PC;
  - a retirement stall, i.e. a watchdog timeout.
- Status and trace readback replace per-cycle bench-side bookkeeping. The bench and an FPGA debug path share the same logic.

Parameters:
- PC_WIDTH, 32, width of the monitored PC.
- CNT_WIDTH, 32, width of the retire and cycle counters; both saturate.
- TRACE_DEPTH, 16, ring-buffer entries; power of two, >=2.
- TIMEOUT_CYCLES, 1024, consecutive cycles without a retirement before timeout; >=2.
- HALT_REPEAT, 4, consecutive retirements of the same PC that declare a halt; >=2.

Ports:
- i_clk  in  1  core clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous clear of counters, trace, flags and FSM (returns to IDLE).
- i_insn_vld  in  1  retirement strobe from the core (o_insn_vld).
- i_pc  in  PC_WIDTH  retired PC (o_pc_debug); valid when i_insn_vld=1.
- i_trace_idx  in  $clog2(TRACE_DEPTH)  readback index; 0 = most recent retirement.
- o_trace_pc  out  PC_WIDTH  PC at i_trace_idx (combinational read).
- o_trace_vld  out  1  entry at i_trace_idx has been written since reset/clear.
- o_retire_cnt  out  CNT_WIDTH  retired instructions.
- o_cycle_cnt  out  CNT_WIDTH  cycles spent in RUN.
- o_running  out  1  FSM in RUN.
- o_halted  out  1  sticky halt flag.
- o_timeout  out  1  sticky timeout flag.
- o_halt_pc  out  PC_WIDTH  PC at which the halt was detected.

Behaviour:
- Reset (async, i_rst_n=0): every output and internal register is 0; FSM enters IDLE. i_clear=1 has the same effect at the next rising edge and overrides all other inputs that cycle.
- FSM states and transitions:
  - IDLE → RUN on the first i_insn_vld=1. That retirement is counted and traced. The cycle counter starts at 1 on that edge.
  - RUN → HALTED when the halt condition below is met.
  - RUN → TIMEOUT when the idle counter reaches TIMEOUT_CYCLES.
  - HALTED and TIMEOUT are terminal until reset or clear.
- Retirement in IDLE or RUN:
  - o_retire_cnt increments by 1, saturating at all-ones.
  - i_pc is written at the write pointer; the pointer advances modulo TRACE_DEPTH and wraps silently, overwriting the oldest entry.
  - The fill count increments, saturating at TRACE_DEPTH.
- In HALTED and TIMEOUT, retirements are ignored: counters and trace freeze.
- Cycle counter: o_cycle_cnt increments every cycle in RUN, saturating.
- Idle counter (RUN only):
  - Resets to 0 on any retirement; otherwise increments.
  - When it reaches TIMEOUT_CYCLES, o_timeout=1 on that edge.
  - Timeout fires exactly TIMEOUT_CYCLES cycles after the last retirement edge.
- Halt detection:
  - A repeat counter tracks consecutive retirements with i_pc equal to the previously retired PC.
  - A different PC sets the repeat count to 1.
  - The first retirement after IDLE counts as 1.
  - When a retirement brings the count to HALT_REPEAT: o_halted=1 and o_halt_pc=i_pc, registered on that edge.
  - That retirement is still counted and traced.
  - Cycles without retirement do not break the repeat run.
- Simultaneous events:
  - If a retirement completes the halt on the same edge the idle counter would hit the limit, the retirement wins: idle counter clears and HALTED is entered.
  - o_halted and o_timeout are never both 1.
- Trace read:
  - o_trace_pc = entry at (wr_ptr-1-i_trace_idx) mod TRACE_DEPTH.
  - o_trace_vld = (i_trace_idx < fill count).
  - When o_trace_vld=0, o_trace_pc=0.
- Latency: all counts and flags update on the edge that samples the event and are visible in the following cycle. Trace read is zero-latency from i_trace_idx.
- Reset mid-run: everything returns immediately to reset values. No partial state survives.
- The first retirement after reset or clear is always accepted.

Test Plan:
- Reset then no retirement for 2000 cycles -> FSM stays IDLE; o_timeout=0, o_cycle_cnt=0, o_trace_vld=0 for all indices.
- Retire PCs 0x0,0x4,...,0x4C (20 back-to-back), DEPTH=16 -> o_retire_cnt=20, o_cycle_cnt=20; idx0=0x4C, idx15=0x10, all valid. After clear: counts 0 and trace invalid.
- Retire 0x100,0x104, then 0x108 four times with 2-cycle gaps -> o_halted=1 after the 4th 0x108; o_halt_pc=0x108, o_retire_cnt=6. Later retirements change nothing.
- Retire 0x200, then silence -> o_timeout rises exactly 1024 cycles after the retire edge; o_running drops in the same cycle; o_halted=0.
- 3rd repeat of 0x300 followed by the 4th repeat arriving on the edge where the idle count would hit TIMEOUT_CYCLES (TIMEOUT_CYCLES=8) -> o_halted=1, o_timeout=0.
- Assert i_rst_n=0 mid-run after 5 retirements -> all outputs 0 asynchronously; the next retirement restarts counts at 1.
